// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU host sequencer: opcodes, ALU IO-pin
// bit positions, command payload and FSM state encoding.
package alu_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned OP_W   = 3;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [OP_W-1:0] {
    OP_ADD   = 3'd0,
    OP_SUB   = 3'd1,
    OP_AND   = 3'd2,
    OP_OR    = 3'd3,
    OP_XOR   = 3'd4,
    OP_SHL   = 3'd5,
    OP_SHR   = 3'd6,
    OP_PASSB = 3'd7
  } alu_op_e;

  // alu_uio pin map: [2:0] op, [3] load_a, [4] go, [7:5] tied low
  localparam int unsigned UIO_OP_LSB = 0;
  localparam int unsigned UIO_LOAD_A = 3;
  localparam int unsigned UIO_GO     = 4;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [OP_W-1:0]   op;
  } alu_cmd_t;

  localparam int unsigned CMD_W = $bits(alu_cmd_t);

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_LOAD_A = 3'd1;
  localparam state_t ST_LOAD_B = 3'd2;
  localparam state_t ST_WAIT   = 3'd3;
  localparam state_t ST_HOLD   = 3'd4;

  function automatic logic [DATA_W-1:0] uio_pack(input logic [OP_W-1:0] op,
                                                 input logic load_a,
                                                 input logic go);
    logic [DATA_W-1:0] v;
    v                        = '0;
    v[UIO_OP_LSB +: OP_W]    = op;
    v[UIO_LOAD_A]            = load_a;
    v[UIO_GO]                = go;
    return v;
  endfunction

endpackage

// File: rtl/alu_host_seq_if.sv
// Host-side command/response handshake bundle for the ALU sequencer.
interface alu_host_seq_if;
  import alu_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [DATA_W-1:0] cmd_a;
  logic [DATA_W-1:0] cmd_b;
  logic [OP_W-1:0]   cmd_op;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_op, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/alu_cmd_fifo.sv
// Command FIFO: power-of-two depth, registered level/full/empty flags.
module alu_cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 19
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       din_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       dout_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             do_push, do_pop;

  // A push at full is refused even when a pop lands in the same cycle
  assign do_push = push_i & ~full_q;
  assign do_pop  = pop_i & ~empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    level_d = level_q + LVL_W'(do_push) - LVL_W'(do_pop);
    full_d  = (level_d == LVL_W'(DEPTH));
    empty_d = (level_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign level_o = level_q;

endmodule

// File: rtl/alu_host_seq.sv
// Drives an external ALU over its pin protocol from a queued command stream:
// load A, then B with op and go, wait LAT cycles, capture and hold the result.
module alu_host_seq
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned LAT   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  alu_host_seq_if.slave          host,
  output logic [DATA_W-1:0]      alu_ui,
  output logic [DATA_W-1:0]      alu_uio,
  input  logic [DATA_W-1:0]      alu_uo,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic [DATA_W-1:0] ui_q, ui_d;
  logic [DATA_W-1:0] uio_q, uio_d;
  logic              busy_q, busy_d;

  alu_cmd_t          push_cmd;
  alu_cmd_t          fifo_head;
  logic              fifo_full, fifo_empty, fifo_pop, push_acc;
  logic [LVL_W-1:0]  fifo_level, lvl_nxt;

  assign push_cmd = {host.cmd_a, host.cmd_b, host.cmd_op};
  assign push_acc = host.cmd_valid & ~fifo_full;

  alu_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (host.cmd_valid),
    .din_i   (push_cmd),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  // Pin outputs are computed for the state being entered so they register
  // in step with it; the counter holds LAT during LOAD_B and counts down.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    b_d         = b_q;
    op_d        = op_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    ui_d        = '0;
    uio_d       = '0;
    fifo_pop    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          b_d      = fifo_head.b;
          op_d     = fifo_head.op;
          ui_d     = fifo_head.a;
          uio_d    = uio_pack(fifo_head.op, 1'b1, 1'b0);
          state_d  = ST_LOAD_A;
        end
      end
      ST_LOAD_A: begin
        ui_d    = b_q;
        uio_d   = uio_pack(op_q, 1'b0, 1'b1);
        cnt_d   = CNT_W'(LAT);
        state_d = ST_LOAD_B;
      end
      ST_LOAD_B, ST_WAIT: begin
        if (cnt_q == CNT_W'(1)) begin
          rsp_data_d  = alu_uo;
          rsp_valid_d = 1'b1;
          state_d     = ST_HOLD;
        end else begin
          cnt_d   = cnt_q - CNT_W'(1);
          state_d = ST_WAIT;
        end
      end
      ST_HOLD: begin
        if (host.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    lvl_nxt = fifo_level + LVL_W'(push_acc) - LVL_W'(fifo_pop);
    busy_d  = (state_d != ST_IDLE) || (lvl_nxt != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      b_q         <= '0;
      op_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      ui_q        <= '0;
      uio_q       <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      b_q         <= b_d;
      op_q        <= op_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      ui_q        <= ui_d;
      uio_q       <= uio_d;
      busy_q      <= busy_d;
    end
  end

  assign host.cmd_ready = ~fifo_full;
  assign host.rsp_valid = rsp_valid_q;
  assign host.rsp_data  = rsp_data_q;
  assign alu_ui         = ui_q;
  assign alu_uio        = uio_q;
  assign busy           = busy_q;
  assign level          = fifo_level;

endmodule

// File: tb/tb_alu_host_seq.sv
// Directed bench for alu_host_seq (DEPTH=4, LAT=2) against a pin-level ALU model.
module tb_alu_host_seq;
  import alu_pkg::*;

  logic       clk;
  logic       rst;
  logic [7:0] alu_ui, alu_uio, alu_uo;
  logic       busy;
  logic [2:0] level;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int vcnt   = 0;
  logic [7:0] got[$];
  int         got_cyc[$];
  logic [7:0] a_reg;

  alu_host_seq_if host_if();

  alu_host_seq #(.DEPTH(4), .LAT(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .host    (host_if),
    .alu_ui  (alu_ui),
    .alu_uio (alu_uio),
    .alu_uo  (alu_uo),
    .busy    (busy),
    .level   (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SHL:  return a << b[2:0];
      OP_SHR:  return a >> b[2:0];
      default: return b;
    endcase
  endfunction

  // ALU model: result appears for exactly one cycle, the one after go; junk otherwise
  always @(posedge clk) begin
    if (alu_uio[UIO_LOAD_A]) a_reg <= alu_ui;
    alu_uo <= alu_uio[UIO_GO] ? alu_f(alu_uio[2:0], a_reg, alu_ui) : 8'hC3;
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst && host_if.rsp_valid && host_if.rsp_ready) begin
      got.push_back(host_if.rsp_data);
      got_cyc.push_back(cyc);
    end
    if (!rst && host_if.rsp_valid) vcnt <= vcnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    int n = 0;
    host_if.cmd_a     = a;
    host_if.cmd_b     = b;
    host_if.cmd_op    = op;
    host_if.cmd_valid = 1'b1;
    while (!host_if.cmd_ready && n < 100) begin
      tick();
      n++;
    end
    chk("push_ready", 32'(host_if.cmd_ready), 32'd1);
    tick();
    host_if.cmd_valid = 1'b0;
  endtask

  task automatic wait_got(input int n, input string tag);
    int k = 0;
    while (got.size() < n && k < 200) begin
      tick();
      k++;
    end
    chk(tag, 32'(got.size()), 32'(n));
  endtask

  task automatic wait_rsp_valid(input string tag);
    int k = 0;
    while (!host_if.rsp_valid && k < 20) begin
      tick();
      k++;
    end
    chk(tag, 32'(host_if.rsp_valid), 32'd1);
  endtask

  logic [7:0] exp2 [6]  = '{8'h48, 8'h30, 8'h3F, 8'hF0, 8'h01, 8'hFF};
  logic [7:0] exp3 [4]  = '{8'h42, 8'h05, 8'h66, 8'h99};
  logic [7:0] sa   [10] = '{8'h01, 8'h10, 8'hAA, 8'hA0, 8'h5A, 8'h03, 8'h80, 8'h11, 8'h7F, 8'h00};
  logic [7:0] sb   [10] = '{8'h02, 8'h01, 8'h0F, 8'h05, 8'hFF, 8'h02, 8'h03, 8'h77, 8'h01, 8'h02};
  logic [2:0] sop  [10] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1};
  logic [7:0] sexp [10] = '{8'h03, 8'h0F, 8'h0A, 8'hA5, 8'hA5, 8'h0C, 8'h10, 8'h77, 8'h80, 8'hFE};

  initial begin
    #500000;
    $display("FAIL watchdog expired before end of sequence");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0;
    rst               = 1'b1;
    host_if.cmd_valid = 1'b0;
    host_if.cmd_a     = '0;
    host_if.cmd_b     = '0;
    host_if.cmd_op    = '0;
    host_if.rsp_ready = 1'b0;
    repeat (3) tick();

    // Reset state: {rsp_valid, rsp_data, alu_ui, alu_uio, busy, level, cmd_ready}
    chk("reset_outputs", 32'({host_if.rsp_valid, host_if.rsp_data, alu_ui, alu_uio, busy, level, host_if.cmd_ready}),
        32'({1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 3'd0, 1'b1}));
    rst = 1'b0;

    // Single ADD command; first push right after reset release
    push(8'h12, 8'h34, OP_ADD);
    chk("t1_level_after_push", 32'(level), 32'd1);
    chk("t1_busy_after_push", 32'(busy), 32'd1);
    tick();
    chk("t1_load_a", 32'({alu_ui, alu_uio}), 32'({8'h12, 8'h08}));
    chk("t1_level_after_pop", 32'(level), 32'd0);
    tick();
    chk("t1_load_b_go", 32'({alu_ui, alu_uio}), 32'({8'h34, 8'h10}));
    tick();
    chk("t1_wait_pins", 32'({alu_ui, alu_uio, host_if.rsp_valid}), 32'({8'h00, 8'h00, 1'b0}));
    tick();
    chk("t1_rsp_valid_5th_edge", 32'(host_if.rsp_valid), 32'd1);
    chk("t1_rsp_data", 32'(host_if.rsp_data), 32'h46);
    host_if.rsp_ready = 1'b1;
    tick();
    chk("t1_rsp_cleared", 32'({host_if.rsp_valid, busy}), 32'd0);
    chk("t1_got", 32'(got.size() == 1 ? got[0] : 8'h00), 32'h46);

    // Fill the FIFO behind a held result, stall a 5th push, then drain in order
    host_if.rsp_ready = 1'b0;
    push(8'h50, 8'h08, OP_SUB);
    wait_rsp_valid("t2_c0_valid");
    chk("t2_c0_data", 32'(host_if.rsp_data), 32'h48);
    push(8'hF0, 8'h3C, OP_AND);
    push(8'h0F, 8'h30, OP_OR);
    push(8'hFF, 8'h0F, OP_XOR);
    push(8'hFF, 8'h02, OP_ADD);
    chk("t2_full", 32'({level, host_if.cmd_ready}), 32'({3'd4, 1'b0}));
    host_if.cmd_a     = 8'h00;
    host_if.cmd_b     = 8'h01;
    host_if.cmd_op    = OP_SUB;
    host_if.cmd_valid = 1'b1;
    tick();
    tick();
    chk("t2_fifth_stalls", 32'({level, host_if.cmd_ready}), 32'({3'd4, 1'b0}));
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("t2_hold_stable", 32'({host_if.rsp_valid, host_if.rsp_data, alu_uio, level, busy}),
          32'({1'b1, 8'h48, 8'h00, 3'd4, 1'b1}));
    end
    got.delete();
    got_cyc.delete();
    host_if.rsp_ready = 1'b1;
    begin
      int k = 0;
      while (!host_if.cmd_ready && k < 50) begin
        tick();
        k++;
      end
    end
    tick();
    host_if.cmd_valid = 1'b0;
    wait_got(6, "t2_count");
    for (int i = 0; i < 6; i++)
      chk($sformatf("t2_order_%0d", i), 32'(got.size() > i ? got[i] : 8'h00), 32'(exp2[i]));
    chk("t2_idle_after_drain", 32'({busy, level}), 32'd0);

    // Simultaneous push and pop with two entries queued
    host_if.rsp_ready = 1'b0;
    got.delete();
    got_cyc.delete();
    push(8'h20, 8'h22, OP_ADD);
    wait_rsp_valid("t3_d0_valid");
    push(8'h09, 8'h04, OP_SUB);
    push(8'h6F, 8'hF6, OP_AND);
    chk("t3_level_before", 32'(level), 32'd2);
    host_if.rsp_ready = 1'b1;
    tick();
    host_if.cmd_a     = 8'h81;
    host_if.cmd_b     = 8'h18;
    host_if.cmd_op    = OP_OR;
    host_if.cmd_valid = 1'b1;
    tick();
    host_if.cmd_valid = 1'b0;
    chk("t3_level_push_pop", 32'(level), 32'd2);
    wait_got(4, "t3_count");
    for (int i = 0; i < 4; i++)
      chk($sformatf("t3_order_%0d", i), 32'(got.size() > i ? got[i] : 8'h00), 32'(exp3[i]));

    // Stream ten commands with the consumer always ready
    got.delete();
    got_cyc.delete();
    for (int i = 0; i < 10; i++) push(sa[i], sb[i], sop[i]);
    wait_got(10, "t4_count");
    for (int i = 0; i < 10; i++)
      chk($sformatf("t4_data_%0d", i), 32'(got.size() > i ? got[i] : 8'h00), 32'(sexp[i]));
    for (int i = 1; i < 10; i++)
      chk($sformatf("t4_spacing_%0d", i), 32'(got_cyc.size() > i ? got_cyc[i] - got_cyc[i-1] : 0), 32'd5);

    // Reset while an operation is in WAIT with two commands queued
    push(8'h01, 8'h01, OP_ADD);
    push(8'h02, 8'h02, OP_ADD);
    push(8'h03, 8'h03, OP_ADD);
    tick();
    chk("t5_wait_level", 32'({level, host_if.rsp_valid, alu_uio}), 32'({3'd2, 1'b0, 8'h00}));
    rst = 1'b1;
    #1;
    chk("t5_async_reset", 32'({host_if.rsp_valid, host_if.rsp_data, alu_ui, alu_uio, busy, level, host_if.cmd_ready}),
        32'({1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 3'd0, 1'b1}));
    #3;
    rst = 1'b0;
    got.delete();
    got_cyc.delete();
    v0 = vcnt;
    repeat (20) tick();
    chk("t5_no_late_rsp", 32'(got.size()), 32'd0);
    chk("t5_no_late_valid", 32'(vcnt - v0), 32'd0);
    chk("t5_idle", 32'({busy, level}), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_host_seq.md
ALU_HOST_SEQ -- requirements
Module: alu_host_seq

Interface
REQ-001 SHALL have parameter DEPTH, default 4: command FIFO entries, power of two, 2..16.
REQ-002 SHALL have parameter LAT, default 2: cycles from go-strobe to valid ALU result, 1..15.
REQ-003 clk  in  1  sole clock, all state on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 cmd_valid  in  1  command offered.
REQ-006 cmd_ready  out  1  FIFO can accept; transfer when cmd_valid&cmd_ready.
REQ-007 cmd_a / cmd_b  in  8 each  operands A and B.
REQ-008 cmd_op  in  3  ALU opcode.
REQ-009 rsp_valid  out  1  result held.
REQ-010 rsp_ready  in  1  consumer accepts; transfer when rsp_valid&rsp_ready.
REQ-011 rsp_data  out  8  captured ALU result.
REQ-012 alu_ui  out  8  to ALU dedicated inputs (operand byte).
REQ-013 alu_uio  out  8  to ALU IO inputs: [2:0] op, [3] load_a, [4] go, [7:5] zero.
REQ-014 alu_uo  in  8  from ALU dedicated outputs (result).
REQ-015 busy  out  1  high when FSM not IDLE or FIFO non-empty.
REQ-016 level  out  $clog2(DEPTH)+1  FIFO occupancy.

Function
REQ-017 SHALL act as initiator of the ALU pin protocol: load A, then B with op and go, wait LAT cycles, sample result.
REQ-018 cmd_ready SHALL equal (level != DEPTH); push stores {a,b,op}.
REQ-019 FSM states IDLE, LOAD_A, LOAD_B, WAIT, HOLD.
REQ-020 IDLE: if FIFO non-empty, pop head, register it, go to LOAD_A next cycle; else stay.
REQ-021 LOAD_A (1 cycle): alu_ui=A, load_a=1, go=0, op=held op -> LOAD_B.
REQ-022 LOAD_B (1 cycle): alu_ui=B, load_a=0, go=1, op=held op; counter loaded with LAT -> WAIT.
REQ-023 WAIT: counter decrements each cycle; on the cycle it reaches 1, alu_uo captured into rsp_data, rsp_valid set -> HOLD; sampled result is alu_uo exactly LAT cycles after the go cycle.
REQ-024 HOLD: rsp_valid=1, rsp_data stable; on rsp_ready -> IDLE with rsp_valid cleared next cycle.
REQ-025 In IDLE, WAIT and HOLD, alu_ui=0 and alu_uio=0.
REQ-026 Push and pop in same cycle at full SHALL be disallowed (cmd_ready=0); at any other level simultaneous push/pop leaves level unchanged, data ordering FIFO.
REQ-027 Pointers SHALL wrap modulo DEPTH; level never exceeds DEPTH nor underflows.
REQ-028 Commands SHALL complete strictly in acceptance order; one outstanding ALU operation at most.
REQ-029 Throughput with rsp_ready held high: one result every LAT+3 cycles.
REQ-030 Backpressure (rsp_ready=0) SHALL stall the FSM in HOLD indefinitely without losing FIFO contents; pushes continue until full.

Reset
REQ-031 rst SHALL asynchronously force IDLE, level=0, pointers=0, rsp_valid=0, rsp_data=0, alu_ui=0, alu_uio=0, busy=0; cmd_ready=1 after reset.
REQ-032 rst mid-operation SHALL abandon the in-flight command and all queued commands; no rsp_valid follows.
REQ-033 After rst deasserts, first push SHALL be accepted on the next rising edge.

Structure
REQ-034 Shared package alu_pkg SHALL hold opcode enum (3-bit), alu_uio bit-position constants, FSM state typedef.
REQ-035 FIFO SHALL be a separate sub-module alu_cmd_fifo (parameter DEPTH, width 19); FSM, counter and output registers in alu_host_seq.
REQ-036 All outputs SHALL be registered.

Verification
REQ-037 Single command A=0x12, B=0x34, op=ADD, ALU model returns A+B after LAT=2 -> alu_uio shows load_a then go with op, rsp_data=0x46 at rsp_valid, rsp_valid first high 5 cycles after push.
REQ-038 Push 4 commands back-to-back, DEPTH=4 -> level reaches 4, cmd_ready=0, 5th push stalls; responses return in push order.
REQ-039 rsp_ready held 0 for 20 cycles after first result -> rsp_valid and rsp_data stable, FSM in HOLD, alu_uio=0, queued commands intact.
REQ-040 rst pulsed during WAIT with 2 queued -> all outputs 0 immediately, level=0, no later rsp_valid.
REQ-041 Continuous streaming of 10 commands, rsp_ready=1 -> results spaced LAT+3 cycles, FIFO pointers wrap, no loss or duplication.
REQ-042 Simultaneous push and pop at level=2 -> level remains 2, order preserved.
